// File: rtl/proc_flex.sv
// proc_flex: multicycle accumulator-style processor core.
// Eight general registers, an A/G accumulator pair and one shared internal bus.
// Instructions arrive on DIN and are handshaked with Run/Done. Each instruction
// walks the T0..T3 step counter and completes in 2, 3 or 4 cycles.
module proc_flex #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic [WIDTH-1:0] DIN,
    output logic             Done,
    output logic [2:0]       Flags,
    output logic [WIDTH-1:0] BusOut
);

    localparam int IW = WIDTH - 7;
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_LSL = 3'b110;
    localparam logic [2:0] OP_LSR = 3'b111;

    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;
    typedef enum logic [2:0] {SEL_NONE, SEL_OP, SEL_MVT, SEL_RX, SEL_G} bus_sel_t;

    tstep_t   tstep;
    tstep_t   tstep_next;
    bus_sel_t bus_sel;

    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] regs [8];
    logic [2:0]       flags;

    logic done;
    logic rx_load;
    logic a_load;
    logic g_load;
    logic flags_load;

    // Instruction fields: {III, M, rX, D}; rY lives in the low bits of D.
    logic [2:0]    opcode;
    logic          m;
    logic [2:0]    rx;
    logic [2:0]    ry;
    logic [IW-1:0] d;

    assign opcode = ir[WIDTH-1 -: 3];
    assign m      = ir[WIDTH-4];
    assign rx     = ir[WIDTH-5 -: 3];
    assign d      = ir[IW-1:0];
    assign ry     = d[2:0];

    logic signed [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0]        mvt_imm;
    logic [WIDTH-1:0]        op_val;
    logic [WIDTH-1:0]        bus;

    assign imm_sext = {{(WIDTH-IW){d[IW-1]}}, d};
    // Zero-extend D, then shift so D[7:0] lands in the top byte.
    assign mvt_imm  = WIDTH'(d) << (WIDTH - 8);
    assign op_val   = m ? $unsigned(imm_sext) : regs[ry];

    // ALU: returns {carry, result}. Subtract is A + ~B + 1 so carry=1 means no borrow.
    function automatic logic [WIDTH:0] alu_eval(input logic [2:0]       opc,
                                                 input logic [WIDTH-1:0] lhs,
                                                 input logic [WIDTH-1:0] rhs);
        logic [SW-1:0] shamt;
        shamt = rhs[SW-1:0];
        case (opc)
            OP_ADD:         return {1'b0, lhs} + {1'b0, rhs};
            OP_SUB, OP_CMP: return {1'b0, lhs} + {1'b0, ~rhs} + {{WIDTH{1'b0}}, 1'b1};
            OP_AND:         return {1'b0, lhs & rhs};
            OP_LSL:         return {1'b0, lhs << shamt};
            OP_LSR:         return {1'b0, lhs >> shamt};
            default:        return '0;
        endcase
    endfunction

    logic [WIDTH:0]   alu_out;
    logic [WIDTH-1:0] alu_res;
    logic [2:0]       flags_new;

    // The ALU always sees A and the bus; the bus carries OP during T2.
    assign alu_out   = alu_eval(opcode, a, bus);
    assign alu_res   = alu_out[WIDTH-1:0];
    assign flags_new = {(alu_res == '0), alu_res[WIDTH-1], alu_out[WIDTH]};

    // Step counter register.
    always_ff @(posedge Clock) begin
        if (!Resetn) tstep <= T0;
        else         tstep <= tstep_next;
    end

    // Next step: wait in T0 for Run, then advance until the instruction signals Done.
    always_comb begin
        tstep_next = tstep;
        case (tstep)
            T0:      tstep_next = Run ? T1 : T0;
            T1:      tstep_next = done ? T0 : T2;
            T2:      tstep_next = done ? T0 : T3;
            T3:      tstep_next = T0;
            default: tstep_next = T0;
        endcase
    end

    // Per-step control: one bus source plus the register loads for this cycle.
    always_comb begin
        bus_sel    = SEL_NONE;
        done       = 1'b0;
        rx_load    = 1'b0;
        a_load     = 1'b0;
        g_load     = 1'b0;
        flags_load = 1'b0;
        case (tstep)
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus_sel = SEL_OP;
                        rx_load = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVT: begin
                        bus_sel = SEL_MVT;
                        rx_load = 1'b1;
                        done    = 1'b1;
                    end
                    default: begin
                        bus_sel = SEL_RX;
                        a_load  = 1'b1;
                    end
                endcase
            end
            T2: begin
                bus_sel    = SEL_OP;
                flags_load = 1'b1;
                if (opcode == OP_CMP) done   = 1'b1;
                else                  g_load = 1'b1;
            end
            T3: begin
                bus_sel = SEL_G;
                rx_load = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Shared bus multiplexer; idles at zero when nothing drives it.
    always_comb begin
        bus = '0;
        case (bus_sel)
            SEL_OP:  bus = op_val;
            SEL_MVT: bus = mvt_imm;
            SEL_RX:  bus = regs[rx];
            SEL_G:   bus = g;
            default: bus = '0;
        endcase
    end

    // Instruction register captures DIN only when an instruction is accepted.
    always_ff @(posedge Clock) begin
        if (!Resetn)               ir <= '0;
        else if (tstep == T0 && Run) ir <= DIN;
    end

    // Register file writeback from the bus.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (rx_load) begin
            regs[rx] <= bus;
        end
    end

    // Accumulator pair: A holds rX, G holds the ALU result.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            a <= '0;
            g <= '0;
        end else begin
            if (a_load) a <= bus;
            if (g_load) g <= alu_res;
        end
    end

    // Status flags {Z, N, C}, written only in the ALU step.
    always_ff @(posedge Clock) begin
        if (!Resetn)         flags <= '0;
        else if (flags_load) flags <= flags_new;
    end

    assign Done   = done;
    assign Flags  = flags;
    assign BusOut = bus;

endmodule

// File: tb/tb_proc_flex.sv
// Testbench for proc_flex (WIDTH=16): directed cases plus randomized
// instruction streams checked against an arithmetic reference model.
module tb_proc_flex;

    logic        Clock  = 1'b0;
    logic        Resetn = 1'b0;
    logic        Run    = 1'b0;
    logic [15:0] DIN    = '0;
    logic        Done;
    logic [2:0]  Flags;
    logic [15:0] BusOut;

    proc_flex #(.WIDTH(16)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .Done   (Done),
        .Flags  (Flags),
        .BusOut (BusOut)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    // Reference state
    int         m_regs [8];
    logic [2:0] m_flags;

    // Observations from the last executed instruction
    int          obs_cycles;
    logic [15:0] obs_bus;
    logic [2:0]  obs_flags;
    logic        obs_t0_done;

    // Reference model: computes the architectural effect of one instruction.
    task automatic model_exec(input logic [15:0] din, output int cyc,
                              output logic [15:0] bus, output logic [2:0] fl);
        int opc, rx, d, ry, op, a, r;
        bit m, c;
        opc = int'(din[15:13]);
        m   = din[12];
        rx  = int'(din[11:9]);
        d   = int'(din[8:0]);
        ry  = d % 8;
        a   = m_regs[rx];
        op  = m ? (((d ^ 256) - 256) & 32'hFFFF) : m_regs[ry];
        c   = 1'b0;
        r   = 0;
        fl  = m_flags;
        if (opc == 0) begin
            m_regs[rx] = op;
            bus = 16'(op);
            cyc = 2;
        end else if (opc == 1) begin
            r = (d % 256) * 256;
            m_regs[rx] = r;
            bus = 16'(r);
            cyc = 2;
        end else begin
            case (opc)
                2: begin r = a + op; c = (r >= 65536); end
                3, 5: begin c = (a >= op); r = a - op; end
                4: r = a & op;
                6: r = a << (op % 16);
                default: r = a >> (op % 16);
            endcase
            r  = r & 32'hFFFF;
            fl = {(r == 0), (r >= 32768), c};
            if (opc == 5) begin
                bus = 16'(op);
                cyc = 3;
            end else begin
                m_regs[rx] = r;
                bus = 16'(r);
                cyc = 4;
            end
        end
        m_flags = fl;
    endtask

    // Drive one instruction from T0 and follow it to Done (bounded).
    task automatic exec(input logic [15:0] din, input bit keep_run);
        int cnt;
        bit seen;
        DIN = din;
        Run = 1'b1;
        @(negedge Clock);
        obs_t0_done = Done;
        @(posedge Clock); #1;
        if (!keep_run) Run = 1'b0;
        cnt  = 2;
        seen = 1'b0;
        obs_bus = 'x;
        while (!seen && cnt <= 8) begin
            @(negedge Clock);
            if (Done) begin
                seen = 1'b1;
                obs_bus = BusOut;
            end else begin
                @(posedge Clock); #1;
                cnt++;
            end
        end
        @(posedge Clock); #1;
        obs_cycles = seen ? cnt : -1;
        obs_flags  = Flags;
    endtask

    // Observe a register by moving it onto itself and sampling the bus.
    task automatic read_reg(input int k, output logic [15:0] v);
        logic [2:0] kk;
        kk = 3'(k);
        exec({3'b000, 1'b0, kk, 6'b000000, kk}, 1'b0);
        v = obs_bus;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_flags = 3'b000;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        Resetn = 1'b0;
        Run    = 1'b0;
        DIN    = '0;
        @(posedge Clock); #1;
        Resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            tests++;
            if ({Done, Flags, BusOut} !== 20'h0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: Done=%b Flags=%b BusOut=%h, want 0/000/0000",
                         i, Done, Flags, BusOut);
            end
            @(posedge Clock); #1;
        end
        tests++;
        if (dut.g !== 16'h0) begin
            fails++;
            $display("FAIL reset_g: got %h want 0000", dut.g);
        end
        for (int k = 0; k < 8; k++) begin
            read_reg(k, v);
            tests++;
            if (v !== 16'h0) begin
                fails++;
                $display("FAIL reset_reg r%0d: got %h want 0000", k, v);
            end
        end
    endtask

    task automatic test_directed();
        int ec;
        logic [15:0] eb, v;
        logic [2:0] ef;
        // mv r0,#5
        model_exec(16'h1005, ec, eb, ef);
        exec(16'h1005, 1'b0);
        tests++;
        if (obs_cycles !== 2 || obs_bus !== 16'h0005) begin
            fails++;
            $display("FAIL mv_imm: cycles=%0d bus=%h, want 2/0005", obs_cycles, obs_bus);
        end
        // mv r1,#-1
        model_exec(16'h13FF, ec, eb, ef);
        exec(16'h13FF, 1'b0);
        read_reg(1, v);
        tests++;
        if (v !== 16'hFFFF) begin
            fails++;
            $display("FAIL mv_neg: r1=%h want FFFF", v);
        end
        // add r1,#1 -> wraps to zero with carry
        model_exec(16'h5201, ec, eb, ef);
        exec(16'h5201, 1'b0);
        tests++;
        if (obs_cycles !== 4 || obs_bus !== 16'h0000 || obs_flags !== 3'b101) begin
            fails++;
            $display("FAIL add_wrap: cycles=%0d bus=%h flags=%b, want 4/0000/101",
                     obs_cycles, obs_bus, obs_flags);
        end
        // mvt r2,#0x80
        model_exec(16'h3480, ec, eb, ef);
        exec(16'h3480, 1'b0);
        read_reg(2, v);
        tests++;
        if (v !== 16'h8000) begin
            fails++;
            $display("FAIL mvt: r2=%h want 8000", v);
        end
        // cmp r2,r0 -> 3 cycles, register untouched
        model_exec(16'hA400, ec, eb, ef);
        exec(16'hA400, 1'b0);
        tests++;
        if (obs_cycles !== 3 || obs_flags !== 3'b001) begin
            fails++;
            $display("FAIL cmp: cycles=%0d flags=%b, want 3/001", obs_cycles, obs_flags);
        end
        read_reg(2, v);
        tests++;
        if (v !== 16'h8000) begin
            fails++;
            $display("FAIL cmp_nowrite: r2=%h want 8000", v);
        end
        // lsl r0,#3
        model_exec(16'hD003, ec, eb, ef);
        exec(16'hD003, 1'b0);
        tests++;
        if (obs_cycles !== 4 || obs_bus !== 16'h0028 || obs_flags !== 3'b000) begin
            fails++;
            $display("FAIL lsl: cycles=%0d bus=%h flags=%b, want 4/0028/000",
                     obs_cycles, obs_bus, obs_flags);
        end
        // lsr r0,#1
        model_exec(16'hF001, ec, eb, ef);
        exec(16'hF001, 1'b0);
        read_reg(0, v);
        tests++;
        if (v !== 16'h0014) begin
            fails++;
            $display("FAIL lsr: r0=%h want 0014", v);
        end
    endtask

    // Random instruction stream; keep_run holds Run high for back-to-back issue.
    task automatic test_random(input int n, input bit keep_run);
        int ec;
        logic [15:0] eb, din, v;
        logic [2:0] ef;
        for (int i = 0; i < n; i++) begin
            din = 16'($urandom);
            model_exec(din, ec, eb, ef);
            exec(din, keep_run);
            tests++;
            if (obs_cycles !== ec || obs_bus !== eb || obs_flags !== ef || obs_t0_done !== 1'b0) begin
                fails++;
                $display("FAIL rand[%0d] din=%h b2b=%0d: cycles=%0d bus=%h flags=%b t0done=%b, want %0d/%h/%b/0",
                         i, din, keep_run, obs_cycles, obs_bus, obs_flags, obs_t0_done, ec, eb, ef);
            end
        end
        Run = 1'b0;
        for (int k = 0; k < 8; k++) begin
            read_reg(k, v);
            tests++;
            if (v !== 16'(m_regs[k])) begin
                fails++;
                $display("FAIL rand_reg r%0d b2b=%0d: got %h want %h", k, keep_run, v, 16'(m_regs[k]));
            end
        end
    endtask

    task automatic test_reset_abort();
        int ec;
        logic [15:0] eb, v;
        logic [2:0] ef;
        model_exec(16'h1005, ec, eb, ef);
        exec(16'h1005, 1'b0);
        model_exec(16'h13FF, ec, eb, ef);
        exec(16'h13FF, 1'b0);
        model_exec(16'h5201, ec, eb, ef);
        exec(16'h5201, 1'b0);
        // add r0,r0, then reset during T2
        DIN = 16'h4000;
        Run = 1'b1;
        @(posedge Clock); #1;
        Run = 1'b0;
        @(negedge Clock);
        tests++;
        if (Done !== 1'b0) begin
            fails++;
            $display("FAIL abort_t1_done: got %b want 0", Done);
        end
        @(posedge Clock); #1;
        Resetn = 1'b0;
        @(negedge Clock);
        tests++;
        if (Done !== 1'b0) begin
            fails++;
            $display("FAIL abort_t2_done: got %b want 0", Done);
        end
        @(posedge Clock); #1;
        Resetn = 1'b1;
        model_reset();
        @(negedge Clock);
        tests++;
        if ({Done, Flags, BusOut} !== 20'h0 || dut.g !== 16'h0) begin
            fails++;
            $display("FAIL abort_state: Done=%b Flags=%b BusOut=%h G=%h, want 0/000/0000/0000",
                     Done, Flags, BusOut, dut.g);
        end
        @(posedge Clock); #1;
        for (int k = 0; k < 8; k++) begin
            read_reg(k, v);
            tests++;
            if (v !== 16'h0) begin
                fails++;
                $display("FAIL abort_reg r%0d: got %h want 0000", k, v);
            end
        end
        model_exec(16'h1005, ec, eb, ef);
        exec(16'h1005, 1'b0);
        tests++;
        if (obs_cycles !== 2 || obs_bus !== 16'h0005) begin
            fails++;
            $display("FAIL abort_resume: cycles=%0d bus=%h, want 2/0005", obs_cycles, obs_bus);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(150, 1'b0);
        test_random(150, 1'b1);
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
